// File: rtl/perceptron_sequencer.sv
// ---------------------------------------------------------------------------
// perceptron_sequencer
//
// Drives one perceptron evaluation through an external M-lane pipelined
// weighted-sum datapath. A request latches N_TOTAL input/weight pairs and a
// bias. The pairs go out in K = ceil(N_TOTAL/M) chunks, one chunk per cycle.
// A tag pipe as long as the datapath latency shows when each chunk sum comes
// back. The chunk sums are added up, the bias is added, and the result is
// presented on a valid/ready output together with a fire bit.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   request handshake
//   in_x, in_w            N_TOTAL signed 16-bit lanes, lane j = [16j+15:16j]
//   in_bias               signed 48-bit bias
//   ws_x, ws_w            registered chunk (M lanes) driven to the datapath
//   ws_sum                datapath chunk sum, PIPE_LAT cycles after ws_x/ws_w
//   out_valid / out_ready result handshake
//   out_sum, out_fire     (sum of x*w) + bias modulo 2^48, and !out_sum[47]
//   busy                  sequencer is not idle
// ---------------------------------------------------------------------------
module perceptron_sequencer #(
   parameter int N_TOTAL  = 32,
   parameter int M        = 8,
   parameter int PIPE_LAT = 11
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [16*N_TOTAL-1:0]  in_x,
   input  logic [16*N_TOTAL-1:0]  in_w,
   input  logic [47:0]            in_bias,
   output logic [16*M-1:0]        ws_x,
   output logic [16*M-1:0]        ws_w,
   input  logic [47:0]            ws_sum,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [47:0]            out_sum,
   output logic                   out_fire,
   output logic                   busy
);

   localparam int K    = (N_TOTAL + M - 1) / M;
   localparam int CW   = 16 * M;
   localparam int PW   = CW * K;
   localparam int CNTW = $clog2(K + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

   state_t            r_state;
   state_t            w_nextState;

   logic [PW-1:0]     r_x;
   logic [PW-1:0]     r_w;
   logic [PW-1:0]     w_xPad;
   logic [PW-1:0]     w_wPad;
   logic [47:0]       r_bias;
   logic [47:0]       r_acc;
   logic [CNTW-1:0]   r_chunkCnt;
   logic [CNTW-1:0]   r_resCnt;
   logic [PIPE_LAT-1:0] r_tag;

   logic              w_accept;
   logic              w_tagIn;
   logic              w_tagOut;
   logic              w_lastChunk;
   logic              w_lastResult;
   logic [47:0]       w_accNext;
   logic [47:0]       w_total;

   // The request is zero-extended to a whole number of chunks. Lanes at
   // index N_TOTAL and above therefore go out as zero.
   assign w_xPad = PW'(in_x);
   assign w_wPad = PW'(in_w);

   // A tag enters during every cycle a chunk sits on ws_x/ws_w. It leaves the
   // pipe exactly when that chunk's sum is on ws_sum.
   assign w_accept     = in_valid && in_ready;
   assign w_tagIn      = (r_state == ISSUE);
   assign w_tagOut     = r_tag[PIPE_LAT-1];
   assign w_lastChunk  = (r_state == ISSUE) && (r_chunkCnt == CNTW'(K - 1));
   assign w_lastResult = (r_state == DRAIN) && w_tagOut && (r_resCnt == CNTW'(K - 1));
   assign w_accNext    = r_acc + ws_sum;
   assign w_total      = w_accNext + r_bias;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: issue K chunks, wait for the K-th sum, then hold the
   // result until it is consumed.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept)     w_nextState = ISSUE;
         ISSUE:   if (w_lastChunk)  w_nextState = DRAIN;
         DRAIN:   if (w_lastResult) w_nextState = HOLD;
         HOLD:    if (out_ready)    w_nextState = IDLE;
         default:                   w_nextState = IDLE;
      endcase
   end

   // Handshake outputs decode straight from the state. Requests are taken
   // only in IDLE, so a request and a result handshake never share a cycle.
   always_comb begin
      in_ready  = (r_state == IDLE);
      busy      = (r_state != IDLE);
      out_valid = (r_state == HOLD);
   end

   // Datapath-side registers. On accept, chunk 0 goes straight from the
   // request onto ws_x/ws_w, and the rest is kept pre-shifted so that the
   // next chunk is always in the low bits. Captures follow only the tag pipe.
   // Because reset clears the tags, stale datapath results are never added.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x        <= '0;
         r_w        <= '0;
         r_bias     <= '0;
         r_acc      <= '0;
         r_chunkCnt <= '0;
         r_resCnt   <= '0;
         r_tag      <= '0;
         ws_x       <= '0;
         ws_w       <= '0;
         out_sum    <= '0;
         out_fire   <= 1'b0;
      end else begin
         r_tag <= PIPE_LAT'({r_tag, w_tagIn});
         ws_x  <= '0;
         ws_w  <= '0;
         if (w_tagOut) begin
            r_acc    <= w_accNext;
            r_resCnt <= r_resCnt + CNTW'(1);
         end
         if (w_accept) begin
            r_x        <= w_xPad >> CW;
            r_w        <= w_wPad >> CW;
            r_bias     <= in_bias;
            r_acc      <= '0;
            r_chunkCnt <= '0;
            r_resCnt   <= '0;
            ws_x       <= w_xPad[CW-1:0];
            ws_w       <= w_wPad[CW-1:0];
         end else if ((r_state == ISSUE) && !w_lastChunk) begin
            r_x        <= r_x >> CW;
            r_w        <= r_w >> CW;
            r_chunkCnt <= r_chunkCnt + CNTW'(1);
            ws_x       <= r_x[CW-1:0];
            ws_w       <= r_w[CW-1:0];
         end
         if (w_lastResult) begin
            out_sum  <= w_total;
            out_fire <= ~w_total[47];
         end
      end
   end

endmodule

// File: tb/tb_perceptron_sequencer.sv
// Testbench for perceptron_sequencer. It runs two instances: the default
// build (N_TOTAL=32) and a short build (N_TOTAL=20, K=3). Each instance is fed
// by a behavioural M-lane dot-product datapath with PIPE_LAT cycles of latency
// and no reset. Expected results come from a direct sum of products.
module tb_perceptron_sequencer;

   localparam int PL = 11;

   logic         clk;
   logic         rst_n;
   bit           sel;
   logic         inValid;
   logic         outReady;
   logic [511:0] inX;
   logic [511:0] inW;
   logic [47:0]  inBias;
   logic [511:0] pendX;
   logic [511:0] pendW;
   logic [47:0]  pendB;
   logic [47:0]  lastSum;
   logic         lastFire;

   logic         inReady1, inReady2, outValid1, outValid2;
   logic         outFire1, outFire2, busy1, busy2;
   logic [127:0] wsX1, wsW1, wsX2, wsW2;
   logic [47:0]  wsSum1, wsSum2, outSum1, outSum2;
   logic [47:0]  dp1 [PL];
   logic [47:0]  dp2 [PL];

   logic         oValid, oFire, oInReady, oBusy;
   logic [47:0]  oSum;
   logic [127:0] wsX, wsW;

   int nChecks = 0;
   int nErrors = 0;

   perceptron_sequencer #(.N_TOTAL(32), .M(8), .PIPE_LAT(PL)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid & ~sel), .in_ready(inReady1),
      .in_x(inX), .in_w(inW), .in_bias(inBias), .ws_x(wsX1), .ws_w(wsW1),
      .ws_sum(wsSum1), .out_valid(outValid1), .out_ready(outReady),
      .out_sum(outSum1), .out_fire(outFire1), .busy(busy1));

   perceptron_sequencer #(.N_TOTAL(20), .M(8), .PIPE_LAT(PL)) dut20 (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid & sel), .in_ready(inReady2),
      .in_x(inX[319:0]), .in_w(inW[319:0]), .in_bias(inBias), .ws_x(wsX2),
      .ws_w(wsW2), .ws_sum(wsSum2), .out_valid(outValid2), .out_ready(outReady),
      .out_sum(outSum2), .out_fire(outFire2), .busy(busy2));

   assign oValid   = sel ? outValid2 : outValid1;
   assign oFire    = sel ? outFire2  : outFire1;
   assign oInReady = sel ? inReady2  : inReady1;
   assign oBusy    = sel ? busy2     : busy1;
   assign oSum     = sel ? outSum2   : outSum1;
   assign wsX      = sel ? wsX2      : wsX1;
   assign wsW      = sel ? wsW2      : wsW1;
   assign wsSum1   = dp1[PL-1];
   assign wsSum2   = dp2[PL-1];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Signed 16x16 product, sign-extended to 48 bits
   function automatic logic [47:0] prod(input logic signed [15:0] a, input logic signed [15:0] b);
      logic signed [31:0] p;
      p = a * b;
      return 48'(p);
   endfunction

   // One datapath chunk: the 8-lane dot product
   function automatic logic [47:0] dot(input logic [127:0] x, input logic [127:0] w);
      logic [47:0] s;
      s = '0;
      for (int i = 0; i < 8; i++) s = s + prod(x[16*i +: 16], w[16*i +: 16]);
      return s;
   endfunction

   // Reference neuron: bias plus the sum of the first n products, mod 2^48
   function automatic logic [47:0] refSum(input logic [511:0] x, input logic [511:0] w,
                                          input logic [47:0] b, input int n);
      logic [47:0] s;
      s = b;
      for (int i = 0; i < n; i++) s = s + prod(x[16*i +: 16], w[16*i +: 16]);
      return s;
   endfunction

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   // Behavioural datapaths: the dot product of the chunk, delayed PL cycles
   always @(posedge clk) begin
      dp1[0] <= dot(wsX1, wsW1);
      dp2[0] <= dot(wsX2, wsW2);
      for (int i = 1; i < PL; i++) begin
         dp1[i] <= dp1[i-1];
         dp2[i] <= dp2[i-1];
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One request on the selected instance. The result is checked for value,
   // fire bit and latency. out_ready can be stalled, with an optional pending
   // request held during the stall. resetAt>0 aborts with a reset pulse.
   task automatic applyStimulus(input logic [511:0] x, input logic [511:0] w,
                                input logic [47:0] b, input int stall,
                                input bit pend, input int resetAt);
      int n, k, lat, cyc;
      logic [47:0] expSum;
      n      = sel ? 20 : 32;
      k      = (n + 7) / 8;
      lat    = k + PL + 1;
      expSum = refSum(x, w, b, n);
      inX = x; inW = w; inBias = b; inValid = 1'b1;
      outReady = (stall == 0);
      checkOutput("in_ready_idle", 64'(oInReady), 64'd1);
      @(posedge clk); #1;
      inValid = 1'b0;
      inX = rnd512(); inW = rnd512();
      cyc = 1;
      checkOutput("busy", 64'(oBusy), 64'd1);
      checkOutput("in_ready_busy", 64'(oInReady), 64'd0);
      while (!oValid && cyc < 100) begin
         if (cyc == resetAt) begin
            #2 rst_n = 1'b0;
            #1;
            checkOutput("rst_out_valid", 64'(oValid), 64'd0);
            checkOutput("rst_in_ready", 64'(oInReady), 64'd1);
            checkOutput("rst_busy", 64'(oBusy), 64'd0);
            checkOutput("rst_ws_x", 64'(wsX[63:0]), 64'd0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            outReady = 1'b0;
            return;
         end
         if (sel && cyc == 3) begin
            checkOutput("ws_x_pad", wsX[127:64], 64'd0);
            checkOutput("ws_w_pad", wsW[127:64], 64'd0);
            checkOutput("ws_x_c2", wsX[63:0], x[256 +: 64]);
         end
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("latency", 64'(cyc), 64'(lat));
      checkOutput("out_sum", 64'(oSum), 64'(expSum));
      checkOutput("out_fire", 64'(oFire), 64'(!expSum[47]));
      lastSum  = oSum;
      lastFire = oFire;
      for (int s = 0; s < stall; s++) begin
         if (pend) begin
            inX = pendX; inW = pendW; inBias = pendB; inValid = 1'b1;
         end
         @(posedge clk); #1;
         checkOutput("hold_valid", 64'(oValid), 64'd1);
         checkOutput("hold_sum", 64'(oSum), 64'(expSum));
         checkOutput("hold_in_ready", 64'(oInReady), 64'd0);
      end
      outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
      checkOutput("valid_drop", 64'(oValid), 64'd0);
      checkOutput("in_ready_back", 64'(oInReady), 64'd1);
   endtask

   initial begin
      logic [511:0] ones, neg3, twos, minX, rx, rw;
      logic [47:0]  rb;
      ones = {32{16'h0001}};
      neg3 = {32{16'hFFFD}};
      twos = {32{16'h0002}};
      minX = {32{16'h8000}};
      sel = 1'b0; rst_n = 1'b0; inValid = 1'b0; outReady = 1'b0;
      inX = '0; inW = '0; inBias = '0;
      pendX = '0; pendW = '0; pendB = '0;
      #12;
      checkOutput("reset_in_ready", 64'(inReady1), 64'd1);
      checkOutput("reset_out_valid", 64'(outValid1), 64'd0);
      checkOutput("reset_out_sum", 64'(outSum1), 64'd0);
      checkOutput("reset_out_fire", 64'(outFire1), 64'd0);
      checkOutput("reset_busy", 64'(busy1), 64'd0);
      checkOutput("reset_ws_x", 64'(wsX1[63:0]), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      $display("[TB] case 1: all ones");
      applyStimulus(ones, ones, 48'd0, 0, 1'b0, 0);
      checkOutput("case1_sum", 64'(lastSum), 64'd32);

      $display("[TB] case 2: x=-3 w=2 bias=100");
      applyStimulus(neg3, twos, 48'd100, 0, 1'b0, 0);
      checkOutput("case2_sum", 64'(lastSum), 64'(48'hFFFF_FFFF_FFA4));
      checkOutput("case2_fire", 64'(lastFire), 64'd0);

      $display("[TB] case 3: output stall with pending request");
      pendX = rnd512(); pendW = rnd512(); pendB = {16'($urandom()), $urandom()};
      applyStimulus(ones, ones, 48'd0, 25, 1'b1, 0);
      checkOutput("case3_sum", 64'(lastSum), 64'd32);
      applyStimulus(pendX, pendW, pendB, 0, 1'b0, 0);

      $display("[TB] case 4: N_TOTAL=20");
      sel = 1'b1;
      applyStimulus(ones, ones, 48'd0, 0, 1'b0, 0);
      checkOutput("case4_sum", 64'(lastSum), 64'd20);
      sel = 1'b0;

      $display("[TB] case 5: reset during chunk 2");
      applyStimulus(neg3, twos, 48'd100, 0, 1'b0, 3);
      applyStimulus(ones, ones, 48'd0, 0, 1'b0, 0);
      checkOutput("case5_sum", 64'(lastSum), 64'd32);

      $display("[TB] case 6: most negative operands");
      applyStimulus(minX, minX, 48'hFFF8_0000_0000, 0, 1'b0, 0);
      checkOutput("case6a_sum", 64'(lastSum), 64'd0);
      checkOutput("case6a_fire", 64'(lastFire), 64'd1);
      applyStimulus(minX, minX, 48'hFFF7_FFFF_FFFF, 0, 1'b0, 0);
      checkOutput("case6b_sum", 64'(lastSum), 64'(48'hFFFF_FFFF_FFFF));
      checkOutput("case6b_fire", 64'(lastFire), 64'd0);

      $display("[TB] random requests");
      for (int t = 0; t < 10; t++) begin
         rx  = rnd512();
         rw  = rnd512();
         rb  = {16'($urandom()), $urandom()};
         sel = 1'($urandom_range(0, 1));
         applyStimulus(rx, rw, rb, $urandom_range(0, 3), 1'b0, 0);
      end
      sel = 1'b0;

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
